// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch/redirect slice
//
// Purpose : fetch FSM state encoding, instruction size and the bubble
//           instruction that IF/ID substitutes when if_valid is low.
// Ports   : none (package)

package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } fetch_state_e;

   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_out_buf.sv
// rtl/fetch_out_buf.sv - single-entry output buffer feeding the IF/ID register
//
// Purpose : holds the most recently accepted instruction and its address.
// Ports   :
//   clk, reset  clock, synchronous active-high reset
//   load        capture instr_in / pc_in and mark valid
//   clear       drop the entry (valid <= 0); instr/pc keep their last value
//   instr_in    fetched instruction
//   pc_in       address of instr_in
//   valid       entry holds a live instruction
//   instr, pc   buffered instruction and its address
// With neither load nor clear the entry is held unchanged.

module fetch_out_buf #(
   parameter int PC_W = 9
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            clear,
   input  logic [31:0]     instr_in,
   input  logic [PC_W-1:0] pc_in,
   output logic            valid,
   output logic [31:0]     instr,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         instr <= 32'd0;
         pc    <= '0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= instr_in;
         pc    <= pc_in;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC owner, instruction-fetch handshake and redirect handling
//
// Purpose : issues one PC-addressed fetch at a time, hands accepted instructions
//           to IF/ID through fetch_out_buf, and restarts fetch on a taken
//           branch/jump while flushing IF/ID and ID/EX.
// Ports   :
//   clk, reset   clock, synchronous active-high reset
//   PcSel, BrPC  redirect request and target from the branch unit
//   Stall        hazard-unit stall, IF/ID must hold
//   imem_req     fetch request valid
//   imem_addr    fetch address
//   imem_ack     memory accepted request, imem_rdata valid this cycle
//   imem_rdata   fetched instruction
//   if_valid     if_instr / if_pc hold a live instruction
//   if_instr     instruction to IF/ID
//   if_pc        address of if_instr
//   Flush        clear IF/ID and ID/EX at the next edge
//   misalign     one-cycle pulse after a misaligned / out-of-range target

module fetch_redirect_unit
   import cpu_pkg::*;
#(
   parameter int             PC_W     = 9,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            PcSel,
   input  logic [31:0]     BrPC,
   input  logic            Stall,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            if_valid,
   output logic [31:0]     if_instr,
   output logic [PC_W-1:0] if_pc,
   output logic            Flush,
   output logic            misalign
);

   fetch_state_e    state;
   fetch_state_e    state_next;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] drop_addr;   // address of the request still in flight while in DROP
   logic [PC_W-1:0] target;
   logic            buf_full;
   logic            accept;
   logic            buf_clear;
   logic            abandon;     // redirect leaves an unacknowledged request behind
   logic            bad_target;

   // Buffer cannot take a new instruction while IF/ID refuses the current one.
   assign buf_full   = if_valid && Stall;

   // Target is truncated to the PC width and forced to a word boundary.
   assign target     = {BrPC[PC_W-1:2], 2'b00};
   assign bad_target = (BrPC[1:0] != 2'b00) || ((BrPC >> PC_W) != 32'd0);

   assign accept     = (state == FETCH) && imem_req && imem_ack && !PcSel;
   assign abandon    = (state == FETCH) && PcSel && imem_req && !imem_ack;

   // A redirect kills the entry; otherwise IF/ID consuming it empties the buffer
   // unless a fresh instruction replaces it in the same cycle.
   assign buf_clear  = PcSel || (!Stall && !accept);

   assign Flush      = PcSel && !reset;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            state_next = FETCH;
         end
         FETCH: begin
            if (PcSel) begin
               state_next = abandon ? DROP : FETCH;
            end else if (buf_full) begin
               state_next = HOLD;
            end else begin
               state_next = FETCH;
            end
         end
         HOLD: begin
            if (PcSel || !Stall) begin
               state_next = FETCH;
            end else begin
               state_next = HOLD;
            end
         end
         DROP: begin
            // The stale response completes the old request; pc already holds
            // the most recent target.
            state_next = imem_ack ? FETCH : DROP;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc;
      case (state)
         FETCH: begin
            imem_req  = !buf_full;
            imem_addr = pc;
         end
         DROP: begin
            imem_req  = 1'b1;
            imem_addr = drop_addr;
         end
         default: begin
            imem_req  = 1'b0;
            imem_addr = pc;
         end
      endcase
   end

   // ---------------- PC register and next-PC mux ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (PcSel) begin
         pc <= target;
      end else if (accept) begin
         pc <= pc + PC_W'(INSTR_BYTES);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_addr <= '0;
      end else if (abandon) begin
         drop_addr <= pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         misalign <= 1'b0;
      end else begin
         misalign <= PcSel && bad_target;
      end
   end

   // ---------------- IF/ID output buffer ----------------
   fetch_out_buf #(
      .PC_W (PC_W)
   ) u_out_buf (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .clear    (buf_clear),
      .instr_in (imem_rdata),
      .pc_in    (pc),
      .valid    (if_valid),
      .instr    (if_instr),
      .pc       (if_pc)
   );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - directed self-checking bench for fetch_redirect_unit

module tb_fetch_redirect_unit;

   localparam int PC_W = 9;

   logic            clk = 1'b0;
   logic            reset;
   logic            PcSel;
   logic [31:0]     BrPC;
   logic            Stall;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic            if_valid;
   logic [31:0]     if_instr;
   logic [PC_W-1:0] if_pc;
   logic            Flush;
   logic            misalign;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Memory returns a word tagged with its own address.
   assign imem_rdata = 32'hA000_0000 | {23'd0, imem_addr};

   fetch_redirect_unit #(
      .PC_W     (PC_W),
      .RESET_PC (9'h000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .PcSel      (PcSel),
      .BrPC       (BrPC),
      .Stall      (Stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .Flush      (Flush),
      .misalign   (misalign)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Inputs change at the falling edge; checks follow 1 time unit later.
   task automatic nxt;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; PcSel = 1'b0; BrPC = 32'd0; Stall = 1'b0; imem_ack = 1'b0;

      // ---- reset ----
      nxt; nxt;
      PcSel = 1'b1; BrPC = 32'h0000_0044; imem_ack = 1'b1;
      #1;
      chk_eq("rst_req",      32'(imem_req),  32'd0);
      chk_eq("rst_valid",    32'(if_valid),  32'd0);
      chk_eq("rst_instr",    if_instr,       32'd0);
      chk_eq("rst_pc",       32'(if_pc),     32'd0);
      chk_eq("rst_flush",    32'(Flush),     32'd0);
      nxt;
      chk_eq("rst_misalign", 32'(misalign),  32'd0);
      chk_eq("rst_addr",     32'(imem_addr), 32'd0);

      // ---- streaming with ack tied high ----
      reset = 1'b0; PcSel = 1'b0; BrPC = 32'd0; imem_ack = 1'b1;
      #1;
      chk_eq("idle_req", 32'(imem_req), 32'd0);
      nxt; #1;
      chk_eq("s0_req",   32'(imem_req),  32'd1);
      chk_eq("s0_addr",  32'(imem_addr), 32'h000);
      chk_eq("s0_valid", 32'(if_valid),  32'd0);
      nxt; #1;
      chk_eq("s1_addr",  32'(imem_addr), 32'h004);
      chk_eq("s1_valid", 32'(if_valid),  32'd1);
      chk_eq("s1_ifpc",  32'(if_pc),     32'h000);
      chk_eq("s1_instr", if_instr,       32'hA000_0000);
      nxt; #1;
      chk_eq("s2_addr",  32'(imem_addr), 32'h008);
      chk_eq("s2_ifpc",  32'(if_pc),     32'h004);

      // ---- stall with if_pc = 0x08 for 4 cycles ----
      nxt;
      Stall = 1'b1;
      #1;
      chk_eq("s3_addr",  32'(imem_addr), 32'h00C);
      chk_eq("st_ifpc",  32'(if_pc),     32'h008);
      chk_eq("st_req0",  32'(imem_req),  32'd0);
      for (int i = 1; i < 4; i++) begin
         nxt; #1;
         chk_eq("st_req",   32'(imem_req), 32'd0);
         chk_eq("st_valid", 32'(if_valid), 32'd1);
         chk_eq("st_ifpc",  32'(if_pc),    32'h008);
         chk_eq("st_instr", if_instr,      32'hA000_0008);
      end
      nxt;
      Stall = 1'b0;
      #1;
      chk_eq("rel_req",   32'(imem_req), 32'd0);
      nxt; #1;
      chk_eq("res_req",   32'(imem_req),  32'd1);
      chk_eq("res_addr",  32'(imem_addr), 32'h00C);
      chk_eq("res_valid", 32'(if_valid),  32'd0);

      // ---- ack delayed 3 cycles at 0x10 ----
      nxt;
      imem_ack = 1'b0;
      #1;
      chk_eq("dl_ifpc", 32'(if_pc),     32'h00C);
      chk_eq("dl_addr", 32'(imem_addr), 32'h010);
      for (int i = 0; i < 2; i++) begin
         nxt; #1;
         chk_eq("dl_wait_addr",  32'(imem_addr), 32'h010);
         chk_eq("dl_wait_req",   32'(imem_req),  32'd1);
         chk_eq("dl_wait_valid", 32'(if_valid),  32'd0);
      end
      nxt;
      imem_ack = 1'b1;
      #1;
      chk_eq("dl_ack_addr", 32'(imem_addr), 32'h010);
      nxt; #1;
      chk_eq("dl_valid", 32'(if_valid),  32'd1);
      chk_eq("dl_ifpc",  32'(if_pc),     32'h010);
      chk_eq("dl_instr", if_instr,       32'hA000_0010);
      chk_eq("dl_next",  32'(imem_addr), 32'h014);

      // ---- redirect while request to 0x20 is pending ----
      nxt; nxt;
      #1;
      chk_eq("rd_pre_addr", 32'(imem_addr), 32'h01C);
      nxt;
      imem_ack = 1'b0;
      #1;
      chk_eq("rd_pend_addr", 32'(imem_addr), 32'h020);
      nxt;
      PcSel = 1'b1; BrPC = 32'h0000_0040;
      #1;
      chk_eq("rd_flush", 32'(Flush),     32'd1);
      chk_eq("rd_addr",  32'(imem_addr), 32'h020);
      nxt;
      PcSel = 1'b0; BrPC = 32'd0;
      #1;
      chk_eq("drop_req",   32'(imem_req),  32'd1);
      chk_eq("drop_addr",  32'(imem_addr), 32'h020);
      chk_eq("drop_valid", 32'(if_valid),  32'd0);
      chk_eq("drop_flush", 32'(Flush),     32'd0);
      chk_eq("drop_mis",   32'(misalign),  32'd0);
      nxt;
      imem_ack = 1'b1;
      #1;
      chk_eq("drop_ack_addr", 32'(imem_addr), 32'h020);
      nxt;
      imem_ack = 1'b0;
      #1;
      chk_eq("tgt_addr",  32'(imem_addr), 32'h040);
      chk_eq("tgt_req",   32'(imem_req),  32'd1);
      chk_eq("tgt_valid", 32'(if_valid),  32'd0);
      nxt;
      imem_ack = 1'b1;
      #1;
      nxt; #1;
      chk_eq("tgt_ifpc",  32'(if_pc),  32'h040);
      chk_eq("tgt_instr", if_instr,    32'hA000_0040);

      // ---- misaligned, out-of-range target ----
      nxt;
      PcSel = 1'b1; BrPC = 32'h0000_0203;
      #1;
      chk_eq("mis_flush", 32'(Flush), 32'd1);
      nxt;
      PcSel = 1'b0; BrPC = 32'd0;
      #1;
      chk_eq("mis_pulse", 32'(misalign),  32'd1);
      chk_eq("mis_addr",  32'(imem_addr), 32'h000);
      chk_eq("mis_valid", 32'(if_valid),  32'd0);
      nxt; #1;
      chk_eq("mis_clear", 32'(misalign), 32'd0);
      chk_eq("mis_ifpc",  32'(if_pc),    32'h000);
      chk_eq("mis_vld",   32'(if_valid), 32'd1);

      // ---- redirect and stall together ----
      nxt;
      Stall = 1'b1; PcSel = 1'b1; BrPC = 32'h0000_0100;
      #1;
      chk_eq("ps_flush", 32'(Flush),    32'd1);
      chk_eq("ps_req",   32'(imem_req), 32'd0);
      nxt;
      PcSel = 1'b0; BrPC = 32'd0;
      #1;
      chk_eq("ps_valid", 32'(if_valid),  32'd0);
      chk_eq("ps_addr",  32'(imem_addr), 32'h100);
      chk_eq("ps_req2",  32'(imem_req),  32'd1);
      nxt; #1;
      chk_eq("ps_ifpc",  32'(if_pc),    32'h100);
      chk_eq("ps_full",  32'(imem_req), 32'd0);

      // ---- reset mid-request, late ack ignored ----
      nxt;
      Stall = 1'b0; imem_ack = 1'b0;
      #1;
      chk_eq("mr_addr", 32'(imem_addr), 32'h104);
      nxt;
      reset = 1'b1;
      nxt;
      imem_ack = 1'b1;
      #1;
      chk_eq("mr_req",   32'(imem_req), 32'd0);
      chk_eq("mr_valid", 32'(if_valid), 32'd0);
      nxt;
      reset = 1'b0;
      #1;
      chk_eq("mr_idle_req", 32'(imem_req), 32'd0);
      nxt; #1;
      chk_eq("mr_fetch_addr",  32'(imem_addr), 32'h000);
      chk_eq("mr_fetch_valid", 32'(if_valid),  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
